// File: rtl/bc_pkg.sv
// Shared definitions for the basic-computer control sequencer: states, bus
// source codes, ALU op codes, opcodes and register/IO instruction bit positions.
package bc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_DECODE, S_IND,
    S_E0, S_E1, S_E2, S_EXEC_R, S_EXEC_IO,
    S_INT0, S_INT1, S_INT2
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
                         BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_ADD = 4'b0001, ALU_LDA = 4'b0010,
                         ALU_CMA = 4'b0011, ALU_CIR = 4'b0100, ALU_CIL = 4'b0101,
                         ALU_CLA = 4'b0110, ALU_INC = 4'b0111, ALU_CLE = 4'b1000,
                         ALU_CME = 4'b1001, ALU_NOP = 4'b1111;

  localparam int OP_AND = 0, OP_ADD = 1, OP_LDA = 2, OP_STA = 3,
                 OP_BUN = 4, OP_BSA = 5, OP_ISZ = 6, OP_REG = 7;

  // Register-reference bit positions
  localparam int B_CLA = 11, B_CLE = 10, B_CMA = 9, B_CME = 8, B_CIR = 7, B_CIL = 6,
                 B_INC = 5, B_SPA = 4, B_SNA = 3, B_SZA = 2, B_SZE = 1, B_HLT = 0;
  // I/O bit positions
  localparam int B_INP = 11, B_OUT = 10, B_SKI = 9, B_SKO = 8, B_ION = 7, B_IOF = 6;

  // One-hot of the single bit that acts: order 11,9,7,6,5,10,8,4,3,2,1,0.
  function automatic logic [11:0] prio_pick(input logic [11:0] bits);
    logic [11:0] pick;
    pick = '0;
    if      (bits[11]) pick[11] = 1'b1;
    else if (bits[9])  pick[9]  = 1'b1;
    else if (bits[7])  pick[7]  = 1'b1;
    else if (bits[6])  pick[6]  = 1'b1;
    else if (bits[5])  pick[5]  = 1'b1;
    else if (bits[10]) pick[10] = 1'b1;
    else if (bits[8])  pick[8]  = 1'b1;
    else if (bits[4])  pick[4]  = 1'b1;
    else if (bits[3])  pick[3]  = 1'b1;
    else if (bits[2])  pick[2]  = 1'b1;
    else if (bits[1])  pick[1]  = 1'b1;
    else if (bits[0])  pick[0]  = 1'b1;
    return pick;
  endfunction

endpackage

// File: rtl/bc_ir_decode.sv
// Combinational IR decode: indirect bit, one-hot opcode and the single
// register/IO bit that wins the priority order.
module bc_ir_decode #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] ir,
  output logic          ind,
  output logic [7:0]    op_hot,
  output logic [11:0]   bit_sel
);
  import bc_pkg::*;

  logic [2:0] op;

  assign ind     = ir[DW-1];
  assign op      = ir[DW-2:DW-4];
  assign op_hot  = 8'(1) << op;
  assign bit_sel = prio_pick(ir[11:0]);

endmodule

// File: rtl/bc_ctrl_seq.sv
// Basic-computer control sequencer: state register, interrupt enable and T-step
// counter, with all strobes decoded combinationally from the current state and IR.
module bc_ctrl_seq #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [DW-1:0] ir,
  input  logic          ac_zero,
  input  logic          ac_msb,
  input  logic          e_flag,
  input  logic          dr_zero,
  input  logic          fgi,
  input  logic          fgo,
  output logic [2:0]    bus_sel,
  output logic          ar_ld,
  output logic          ar_inc,
  output logic          ar_clr,
  output logic          pc_ld,
  output logic          pc_inc,
  output logic          pc_clr,
  output logic          dr_ld,
  output logic          dr_inc,
  output logic          ac_ld,
  output logic          ir_ld,
  output logic          tr_ld,
  output logic          mem_re,
  output logic          mem_we,
  output logic [3:0]    alu_op,
  output logic          inp_ld,
  output logic          out_ld,
  output logic          ien,
  output logic          busy,
  output logic [3:0]    sc
);
  import bc_pkg::*;

  if (DW < 16 || AW > DW - 4) begin : g_bad_params
    $error("bc_ctrl_seq: DW must be >= 16 and AW <= DW-4");
  end

  state_t      state, state_next, end_state;
  logic        ien_next;
  logic        ind;
  logic [7:0]  op_hot;
  logic [11:0] bit_sel;

  bc_ir_decode #(.DW(DW)) u_decode (
    .ir      (ir),
    .ind     (ind),
    .op_hot  (op_hot),
    .bit_sel (bit_sel)
  );

  // The interrupt check reads the registered ien, so an ION in this cycle only
  // takes effect at the next instruction boundary.
  assign end_state = (ien && (fgi || fgo)) ? S_INT0 : S_FETCH0;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (run) state_next = S_FETCH0;
      S_FETCH0:  state_next = S_FETCH1;
      S_FETCH1:  state_next = S_DECODE;
      S_DECODE:  if (op_hot[OP_REG]) state_next = ind ? S_EXEC_IO : S_EXEC_R;
                 else                state_next = ind ? S_IND : S_E0;
      S_IND:     state_next = S_E0;
      S_E0:      state_next = (op_hot[OP_STA] || op_hot[OP_BUN]) ? end_state : S_E1;
      S_E1:      state_next = op_hot[OP_ISZ] ? S_E2 : end_state;
      S_E2:      state_next = end_state;
      S_EXEC_R:  state_next = bit_sel[B_HLT] ? S_IDLE : end_state;
      S_EXEC_IO: state_next = end_state;
      S_INT0:    state_next = S_INT1;
      S_INT1:    state_next = S_INT2;
      S_INT2:    state_next = S_FETCH0;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ien_next = ien;
    if (state == S_EXEC_IO && bit_sel[B_ION]) ien_next = 1'b1;
    if (state == S_EXEC_IO && bit_sel[B_IOF]) ien_next = 1'b0;
    if (state == S_INT2)                      ien_next = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ien   <= 1'b0;
      sc    <= '0;
    end else begin
      state <= state_next;
      ien   <= ien_next;
      if (state_next == S_FETCH0)          sc <= '0;
      else if (state != S_IDLE && sc != 4'hF) sc <= sc + 4'd1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus_sel = BUS_NONE;
    alu_op  = ALU_NOP;
    {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc} = '0;
    {ac_ld, ir_ld, tr_ld, mem_re, mem_we, inp_ld, out_ld}         = '0;
    case (state)
      S_FETCH0: begin bus_sel = BUS_PC;  ar_ld = 1'b1; end
      S_FETCH1: begin bus_sel = BUS_MEM; mem_re = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1; end
      S_DECODE: begin bus_sel = BUS_IR;  ar_ld = 1'b1; end
      S_IND:    begin bus_sel = BUS_MEM; mem_re = 1'b1; ar_ld = 1'b1; end
      S_E0: begin
        if (op_hot[OP_STA])      begin bus_sel = BUS_AC; mem_we = 1'b1; end
        else if (op_hot[OP_BUN]) begin bus_sel = BUS_AR; pc_ld = 1'b1; end
        else if (op_hot[OP_BSA]) begin bus_sel = BUS_PC; mem_we = 1'b1; ar_inc = 1'b1; end
        else                     begin bus_sel = BUS_MEM; mem_re = 1'b1; dr_ld = 1'b1; end
      end
      S_E1: begin
        if (op_hot[OP_BSA])      begin bus_sel = BUS_AR; pc_ld = 1'b1; end
        else if (op_hot[OP_ISZ]) dr_inc = 1'b1;
        else begin
          ac_ld = 1'b1;
          if (op_hot[OP_AND])      alu_op = ALU_AND;
          else if (op_hot[OP_ADD]) alu_op = ALU_ADD;
          else if (op_hot[OP_LDA]) alu_op = ALU_LDA;
        end
      end
      S_E2: begin bus_sel = BUS_DR; mem_we = 1'b1; pc_inc = dr_zero; end
      S_EXEC_R: begin
        case (1'b1)
          bit_sel[B_CLA]: begin ac_ld = 1'b1; alu_op = ALU_CLA; end
          bit_sel[B_CMA]: begin ac_ld = 1'b1; alu_op = ALU_CMA; end
          bit_sel[B_CIR]: begin ac_ld = 1'b1; alu_op = ALU_CIR; end
          bit_sel[B_CIL]: begin ac_ld = 1'b1; alu_op = ALU_CIL; end
          bit_sel[B_INC]: begin ac_ld = 1'b1; alu_op = ALU_INC; end
          bit_sel[B_CLE]: begin ac_ld = 1'b1; alu_op = ALU_CLE; end
          bit_sel[B_CME]: begin ac_ld = 1'b1; alu_op = ALU_CME; end
          bit_sel[B_SPA]: pc_inc = !ac_msb;
          bit_sel[B_SNA]: pc_inc = ac_msb;
          bit_sel[B_SZA]: pc_inc = ac_zero;
          bit_sel[B_SZE]: pc_inc = !e_flag;
          default: ;
        endcase
      end
      S_EXEC_IO: begin
        case (1'b1)
          bit_sel[B_INP]: inp_ld = 1'b1;
          bit_sel[B_OUT]: out_ld = 1'b1;
          bit_sel[B_SKI]: pc_inc = fgi;
          bit_sel[B_SKO]: pc_inc = fgo;
          default: ;
        endcase
      end
      S_INT0: begin ar_clr = 1'b1; bus_sel = BUS_PC; tr_ld = 1'b1; end
      S_INT1: begin bus_sel = BUS_TR; mem_we = 1'b1; pc_clr = 1'b1; end
      S_INT2: pc_inc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/bc_ctrl_seq.md
# bc_ctrl_seq

Sequential control unit for the basic-computer datapath: steps each instruction through fetch, decode, indirect, execute and interrupt cycles and drives the register load/increment/clear strobes, the common-bus select, the memory strobes and the ALU op code. It is parametrised in data and address width. It adds multi-cycle execution, ISZ/BSA, I/O instructions, interrupt entry and halt/run control. It sits between the IR/flag registers and the datapath in the top level.

## Interface
- `DW`, 16: data/IR width; must be ≥16.
- `AW`, 12: address width; must be ≤ DW-4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `run` in 1: start strobe; honoured only in IDLE.
- `ir` in DW: IR contents.
- `ac_zero`, `ac_msb`, `e_flag`, `dr_zero`, `fgi`, `fgo` in 1 each: datapath status inputs.
- `bus_sel` out 3: bus source select.
  - 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- `ar_ld`, `ar_inc`, `ar_clr`, `pc_ld`, `pc_inc`, `pc_clr`, `dr_ld`, `dr_inc`, `ac_ld`, `ir_ld`, `tr_ld` out 1 each: register strobes.
- `mem_re`, `mem_we` out 1 each: memory read/write strobes.
- `alu_op` out 4: ALU operation code.
- `inp_ld`, `out_ld` out 1 each: I/O transfer strobes.
- `ien` out 1: interrupt-enable flip-flop.
- `busy` out 1: high whenever state ≠ IDLE.
- `sc` out 4: T-step counter, cleared at each FETCH0.

## Operation
- Instruction fields:
  - I = `ir[DW-1]`.
  - op = `ir[DW-2:DW-4]`.
  - address = `ir[AW-1:0]`.
  - register/IO bits = `ir[11:0]`.
- States and actions. Strobes not listed are 0; `alu_op` defaults to 4'b1111.
  - IDLE: no strobes. Goes to FETCH0 on `run`.
  - FETCH0: `bus_sel`=PC, `ar_ld`.
  - FETCH1: `bus_sel`=MEM, `mem_re`, `ir_ld`, `pc_inc`.
  - DECODE: `bus_sel`=IR, `ar_ld`.
    - op=7 → EXEC_R (I=0) or EXEC_IO (I=1).
    - op<7 with I=1 → IND.
    - op<7 with I=0 → E0.
  - IND: `bus_sel`=MEM, `mem_re`, `ar_ld` → E0.
- Memory-reference execute:
  - AND(0)/ADD(1)/LDA(2):
    - E0: MEM→DR.
    - E1: `ac_ld` with `alu_op` 0000 / 0001 / 0010 respectively.
  - STA(3): E0: `bus_sel`=AC, `mem_we`.
  - BUN(4): E0: `bus_sel`=AR, `pc_ld`.
  - BSA(5):
    - E0: `bus_sel`=PC, `mem_we`, `ar_inc`.
    - E1: `bus_sel`=AR, `pc_ld`.
  - ISZ(6):
    - E0: MEM→DR.
    - E1: `dr_inc`.
    - E2: `bus_sel`=DR, `mem_we`, plus `pc_inc` if `dr_zero`.
- EXEC_R. Only the highest-priority set bit acts; priority order is 11,9,7,6,5,10,8,4,3,2,1,0.
  - Bits 11 / 9 / 7 / 6 / 5 / 10 / 8: `ac_ld` with `alu_op` 0110 / 0011 / 0100 / 0101 / 0111 / 1000 / 1001.
  - Skips drive `pc_inc`:
    - bit 4: if !`ac_msb`.
    - bit 3: if `ac_msb`.
    - bit 2: if `ac_zero`.
    - bit 1: if !`e_flag`.
  - Bit 0 (HLT): next state is IDLE.
- EXEC_IO, same priority scheme:
  - bit 11: `inp_ld`.
  - bit 10: `out_ld`.
  - bit 9: skip if `fgi`.
  - bit 8: skip if `fgo`.
  - bit 7: set `ien`.
  - bit 6: clear `ien`.
- Instruction end (last execute state):
  - If `ien` & (`fgi`|`fgo`) → INT0.
  - Otherwise → FETCH0.
  - HLT goes to IDLE even with an interrupt pending.
- Interrupt sequence:
  - INT0: `ar_clr`, `bus_sel`=PC, `tr_ld`.
  - INT1: `bus_sel`=TR, `mem_we`, `pc_clr`.
  - INT2: `pc_inc`, clear `ien` → FETCH0.

## Timing
- Reset: state=IDLE, `ien`=0, `sc`=0, `busy`=0, `bus_sel`=0, every strobe 0, `alu_op`=4'b1111.
- All outputs are combinational decode of the registered state plus `ir`; `ien` and `sc` are registered.
- Latencies, FETCH0 to next FETCH0:
  - Register/IO instruction: 4 cycles.
  - STA/BUN direct: 4 cycles.
  - AND/ADD/LDA/BSA direct: 5 cycles.
  - ISZ direct: 6 cycles.
  - Indirect adds 1 cycle.
  - Interrupt entry adds 3 cycles.
- `run` while busy: ignored.
- `fgi`/`fgo` are sampled only in the last execute cycle; a flag asserted mid-instruction is honoured at that boundary if still high.
- ION and the interrupt check in the same cycle: the check uses the old `ien`, so interrupt entry is deferred to the following instruction.
- `rst_n` low mid-instruction: IDLE on the next edge, no strobes in that cycle, `ien` cleared.
- `sc` increments every non-IDLE cycle and saturates at 15.

## Structure
- `bc_pkg` holds:
  - state enum;
  - `bus_sel` encodings;
  - `alu_op` localparams;
  - opcode constants (AND..ISZ, REG=7);
  - register/IO bit-index constants.
- Sub-module `bc_ir_decode`: combinational one-hot decode of op, I, and the priority-selected register/IO bit. `bc_ctrl_seq` instantiates it and holds the state register, `ien` and `sc`.

## Test plan
- Reset then `run`:
  - FETCH0 asserts `bus_sel`=2 and `ar_ld`.
  - FETCH1 asserts `mem_re`, `ir_ld` and `pc_inc`.
  - `sc` reads 0, 1, 2.
- `ir`=16'h2005 (LDA direct): E1 `ac_ld` with `alu_op`=0010, next FETCH0 at cycle 5; `ir`=16'hA005 takes 6 cycles with IND `mem_re`+`ar_ld`.
- ISZ with `dr_zero`=1 in E2: `mem_we` and `pc_inc` in the same cycle; with `dr_zero`=0 there is no `pc_inc`.
- `ir`=16'h7004 (SZA) with `ac_zero`=1: `pc_inc`; `ir`=16'h7A00 drives `alu_op`=0110 only.
- ION (16'hF080), then `fgi`=1 during the next instruction: INT0/1/2 strobes in order, `ien`=0 after INT2, then FETCH0.
- HLT (16'h7001) with an interrupt pending: IDLE, `busy`=0. Additional cases:
  - `run` while busy is ignored.
  - `rst_n`=0 mid-BSA gives IDLE next cycle with no `mem_we`.
